dm_trace_mem: RTL and testbench



---
 rtl/dm_trace_mem_pkg.sv | 24 ++
 rtl/dm_trace_mem_trace_fifo.sv | 77 +++++++
 rtl/dm_trace_mem.sv | 63 ++++++
 tb/tb_dm_trace_mem.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dm_trace_mem_pkg.sv
// Shared constants and helpers for the data memory with store trace.
// Record layout is {pc, byte address, data}, MSB first.
package dm_trace_mem_pkg;

    localparam int DM_ADDR_WIDTH = 10;
    localparam int TRACE_REC_W   = 96;
    localparam int PC_LSB        = 64;
    localparam int ADR_LSB       = 32;
    localparam int DAT_LSB       = 0;

    function automatic logic [TRACE_REC_W-1:0] pack_rec(
        input logic [31:0] pc,
        input logic [31:0] adr,
        input logic [31:0] dat
    );
        logic [TRACE_REC_W-1:0] r;
        r = '0;
        r[PC_LSB +: 32]  = pc;
        r[ADR_LSB +: 32] = adr;
        r[DAT_LSB +: 32] = dat;
        return r;
    endfunction

endpackage

// File: rtl/dm_trace_mem_trace_fifo.sv
// Generic synchronous circular-buffer FIFO with sticky drop flag.
// A pop in the same cycle frees space for a push into a full buffer.
module trace_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [PTR_W:0]   count_o,
    output logic             overflow_o
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == FULL_CNT);
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign data_o     = buf_q[rd_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Next-state for pointers, occupancy and the sticky drop flag.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push_ok) wr_d = wr_q + PTR_ONE;
        if (pop_ok)  rd_d = rd_q + PTR_ONE;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (push_i && !push_ok) ovf_d = 1'b1;
    end

    // Control registers; reset discards every pending record.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Record storage needs no reset; validity comes from the count.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) buf_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/dm_trace_mem.sv
// Word-addressed data memory with combinational read, synchronous
// write, and a trace FIFO logging every accepted store.
module dm_trace_mem
    import dm_trace_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DM_ADDR_WIDTH,
    parameter int TRACE_DEPTH = 8,
    parameter int TRACE_PTR_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            PC,
    input  logic [31:0]            DMAdr,
    input  logic                   DMWE,
    input  logic [31:0]            DMDataW,
    output logic [31:0]            DMDataR,
    output logic                   trace_valid,
    output logic [95:0]            trace_data,
    input  logic                   trace_ready,
    output logic [TRACE_PTR_W:0]   trace_count,
    output logic                   trace_overflow
);

    localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           mem_q [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  fifo_empty;
    logic                  fifo_full;

    // Byte offset and upper bits dropped: aligned, wrapping access.
    assign idx     = DMAdr[ADDR_WIDTH+1:2];
    assign DMDataR = mem_q[idx];

    // Store port; reset clears the whole array and blocks the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else if (DMWE) begin
            mem_q[idx] <= DMDataW;
        end
    end

    assign trace_valid = !fifo_empty && !fifo_full ? 1'b1 : !fifo_empty;

    trace_fifo #(
        .WIDTH (TRACE_REC_W),
        .DEPTH (TRACE_DEPTH),
        .PTR_W (TRACE_PTR_W)
    ) u_trace_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (DMWE),
        .data_i     (pack_rec(PC, DMAdr, DMDataW)),
        .pop_i      (trace_ready),
        .data_o     (trace_data),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .count_o    (trace_count),
        .overflow_o (trace_overflow)
    );

endmodule

// File: tb/tb_dm_trace_mem.sv
// Scoreboard bench for dm_trace_mem: array/queue reference model,
// directed scenarios followed by randomized traffic.
module tb_dm_trace_mem;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] DMAdr;
    logic        DMWE;
    logic [31:0] DMDataW;
    logic [31:0] DMDataR;
    logic        trace_valid;
    logic [95:0] trace_data;
    logic        trace_ready;
    logic [3:0]  trace_count;
    logic        trace_overflow;

    dm_trace_mem dut (
        .clk            (clk),
        .reset          (reset),
        .PC             (PC),
        .DMAdr          (DMAdr),
        .DMWE           (DMWE),
        .DMDataW        (DMDataW),
        .DMDataR        (DMDataR),
        .trace_valid    (trace_valid),
        .trace_data     (trace_data),
        .trace_ready    (trace_ready),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m [1024];
    logic [95:0] exp_q [$];
    logic        ovf_m;

    logic        p_rst = 1'b1;
    logic        p_we  = 1'b0;
    logic [31:0] p_adr = '0;
    logic [31:0] p_dat = '0;
    logic [31:0] p_pc  = '0;

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Commit the previous cycle's effect to the model, drive new
    // inputs, then check combinational outputs before the next edge.
    task automatic step(input logic r, input logic we,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] p, input logic rdy);
        @(posedge clk);
        #1;
        if (p_rst) begin
            foreach (mem_m[i]) mem_m[i] = '0;
            exp_q.delete();
            ovf_m = 1'b0;
        end else if (p_we) begin
            mem_m[p_adr[11:2]] = p_dat;
            if (exp_q.size() < 8) exp_q.push_back({p_pc, p_adr, p_dat});
            else ovf_m = 1'b1;
        end
        reset = r; DMWE = we; DMAdr = a; DMDataW = d; PC = p;
        trace_ready = rdy;
        p_rst = r; p_we = we; p_adr = a; p_dat = d; p_pc = p;
        #3;
        chk("DMDataR", {64'b0, DMDataR}, {64'b0, mem_m[a[11:2]]});
        chk("trace_count", {92'b0, trace_count}, 96'(exp_q.size()));
        chk("trace_overflow", {95'b0, trace_overflow}, {95'b0, ovf_m});
    endtask

    // Monitor: validity every cycle, head record on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            chk("trace_valid", {95'b0, trace_valid},
                {95'b0, exp_q.size() != 0});
            if (trace_valid && trace_ready) begin
                if (exp_q.size() == 0) begin
                    chk("trace_pop_empty", {95'b0, trace_valid}, 96'b0);
                end else begin
                    chk("trace_data", trace_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; DMWE = 1'b0; DMAdr = '0; DMDataW = '0;
        PC = '0; trace_ready = 1'b0;
        ovf_m = 1'b0;
        foreach (mem_m[i]) mem_m[i] = '0;

        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // store then load
        step(0, 1, 32'h4, 32'hDEAD_BEEF, 32'h3000, 0);
        step(0, 0, 32'h4, 0, 0, 0);

        // read during write
        step(0, 1, 32'h8, 32'h11, 32'h3004, 0);
        step(0, 1, 32'h8, 32'h22, 32'h3008, 0);
        step(0, 0, 32'h8, 0, 0, 0);

        // address wrap and ignored low bits
        step(0, 1, 32'h1000, 32'h5A5A_5A5A, 32'h300C, 0);
        step(0, 0, 32'h0, 0, 0, 0);
        step(0, 0, 32'h1003, 0, 0, 0);

        for (int i = 0; i < 6; i++) step(0, 0, 32'h4, 0, 0, 1);

        // fill and overflow
        for (int i = 1; i <= 9; i++)
            step(0, 1, 32'h100 + 32'(4 * i), 32'(i), 32'h4000 + 32'(i), 0);
        for (int i = 1; i <= 9; i++)
            step(0, 0, 32'h100 + 32'(4 * i), 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 32'h0, 0, 0, 1);

        // full with simultaneous push and pop
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++)
            step(0, 1, 32'(4 * i), 32'(i), 32'h5000, 0);
        step(0, 1, 32'h40, 32'hA, 32'h5100, 1);
        step(0, 0, 32'h40, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 32'h0, 0, 0, 1);

        // reset mid-drain with a store in the reset cycle
        for (int i = 1; i <= 3; i++)
            step(0, 1, 32'(8 * i), 32'hC0 + 32'(i), 32'h6000, 0);
        step(0, 0, 32'h8, 0, 0, 1);
        step(1, 1, 32'h20, 32'hFFFF_FFFF, 32'h6100, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 32'(4 * i), 0, 0, 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic        r;
            logic        we;
            logic [31:0] a;
            logic        rdy;
            r   = ($urandom_range(0, 199) == 0);
            we  = $urandom_range(0, 1) == 1;
            a   = ($urandom_range(0, 3) == 0) ? $urandom()
                                              : 32'($urandom_range(0, 63));
            rdy = (n % 400 < 200) ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 3) != 0);
            step(r, we, a, $urandom(), $urandom(), rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
